// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-addressed data memory: extracts and extends
// loads, runs SB/SH as a read-modify-write and records the first faulting access.
module load_store_unit #(
  parameter int DEPTH_WORDS = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        fault_clear,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        fault_sticky,
  output logic [31:0] fault_addr_q,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [31:0] mem_rdata,
  output logic        state_dbg_o
);

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} state_t;

  localparam logic [29:0] DEPTH_IDX = 30'(DEPTH_WORDS);

  // Handshake: while stall=1 the core holds every req_* stable; a request completes in the
  // first cycle where req_valid=1 and stall=0 (for SB/SH that is the RMW_WR cycle).
  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] merge_q;
  logic [31:0] merge_d;
  logic        fault_sticky_q;
  logic [31:0] fault_addr_qq;

  logic        active;
  logic        load_legal;
  logic        store_legal;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  cause_raw;
  logic        do_load;
  logic        do_sw;
  logic        do_rmw;
  logic        in_wr;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] word_addr;

  always_comb begin
    word_addr    = {req_addr[31:2], 2'b00};
    active       = (state_q == IDLE) && req_valid && !reset;
    load_legal   = 1'b0;
    store_legal  = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: begin load_legal = 1'b1; store_legal = 1'b1; end
      3'b100, 3'b101:         load_legal = 1'b1;
      default:                ;
    endcase
    misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = req_addr[31:2] >= DEPTH_IDX;
    if (req_we ? !store_legal : !load_legal) cause_raw = 2'd3;
    else if (misaligned)                     cause_raw = 2'd1;
    else if (out_of_range)                   cause_raw = 2'd2;
    else                                     cause_raw = 2'd0;

    fault_cause  = active ? cause_raw : 2'd0;
    fault        = (fault_cause != 2'd0);
    do_load      = active && !fault && !req_we;
    do_sw        = active && !fault && req_we && (req_funct3[1:0] == 2'b10);
    do_rmw       = active && !fault && req_we && (req_funct3[1:0] != 2'b10);
    in_wr        = (state_q == RMW_WR) && !reset;

    mem_read_en  = do_load || do_rmw;
    mem_write_en = do_sw || in_wr;
    stall        = do_rmw;
    mem_addr     = (state_q == RMW_WR) ? addr_q : word_addr;
    mem_wdata    = in_wr ? merge_q : (do_sw ? req_wdata : 32'd0);

    lane_b = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    lane_h = mem_rdata[{req_addr[1], 4'b0000} +: 16];
    load_data = 32'd0;
    if (do_load) begin
      case (req_funct3)
        3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
        3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
        3'b100:  load_data = {24'd0, lane_b};
        3'b101:  load_data = {16'd0, lane_h};
        default: load_data = mem_rdata;
      endcase
    end

    merge_d = mem_rdata;
    if (req_funct3[1:0] == 2'b00) merge_d[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
    else                          merge_d[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= 32'd0;
      merge_q        <= 32'd0;
      fault_sticky_q <= 1'b0;
      fault_addr_qq  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (do_rmw) begin
          addr_q  <= word_addr;
          merge_q <= merge_d;
          state_q <= RMW_WR;
        end
        default: state_q <= IDLE;
      endcase
      // A fresh fault wins over a simultaneous clear and re-arms with the new address.
      if (fault && (!fault_sticky_q || fault_clear)) begin
        fault_sticky_q <= 1'b1;
        fault_addr_qq  <= req_addr;
      end else if (fault_clear) begin
        fault_sticky_q <= 1'b0;
      end
    end
  end

  assign fault_sticky = fault_sticky_q;
  assign fault_addr_q = fault_addr_qq;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios followed by randomized
// traffic checked against a word-array reference model of memory and fault rules.
module tb_load_store_unit;

  localparam int DEPTH = 28;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, fault_clear;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, fault, fault_sticky, mem_read_en, mem_write_en, state_dbg;
  logic [1:0]  fault_cause;
  logic [31:0] load_data, fault_addr_q, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tb_mem [0:31];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .fault_clear(fault_clear), .stall(stall), .load_data(load_data), .fault(fault),
    .fault_cause(fault_cause), .fault_sticky(fault_sticky), .fault_addr_q(fault_addr_q),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_en(mem_read_en),
    .mem_write_en(mem_write_en), .mem_rdata(mem_rdata), .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr[6:2]];
  always @(posedge clk) if (mem_write_en) tb_mem[mem_addr[6:2]] <= mem_wdata;

  // ---------------- reference model ----------------
  function automatic logic [1:0] model_cause(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned size;
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    if (!legal) return 2'd3;
    size = 1 << f3[1:0];
    if (a % size != 0) return 2'd1;
    if (a / 4 >= DEPTH) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w, b, h;
    w = ref_mem[a / 4];
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_merge(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int unsigned sh;
    sh = 8 * (a % 4);
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (ref_mem[a / 4] & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic clr);
    req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; fault_clear = clr;
  endtask

  task automatic idle_cycle();
    @(negedge clk); drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_sw(input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk); drive(1, 1, 3'd2, a, wd, 0);
    @(posedge clk); ref_mem[a / 4] = wd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk); drive(1, 0, 3'd2, 32'h0C, 0, 0); #1;
    vectors++; if (mem_read_en !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b expected 0", mem_read_en); end
    vectors++; if (stall !== 1'b0 || fault !== 1'b0) begin miscompares++; $display("FAIL reset_stall_fault: got %b%b expected 00", stall, fault); end
    vectors++; if (load_data !== 32'd0) begin miscompares++; $display("FAIL reset_load_data: got %h expected 0", load_data); end
    @(posedge clk); #1;
    vectors++; if (state_dbg !== 1'b0 || fault_sticky !== 1'b0 || fault_addr_q !== 32'd0) begin
      miscompares++; $display("FAIL reset_regs: got state %b sticky %b faddr %h expected 0 0 0", state_dbg, fault_sticky, fault_addr_q); end
    @(negedge clk); reset = 1'b0; drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic init_mem();
    for (int i = 0; i < DEPTH; i++) do_sw(32'(i * 4), $urandom());
    idle_cycle();
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [31:0] as  [5] = '{32'h0D, 32'h0D, 32'h0E, 32'h0C, 32'h0C};
    logic [31:0] exps[5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    do_sw(32'h0C, 32'h8899AABB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(1, 0, f3s[i], as[i], 0, 0); #1;
      vectors++; if (load_data !== exps[i] || stall !== 1'b0) begin
        miscompares++; $display("FAIL load_%0d: got %h stall %b expected %h stall 0", i, load_data, stall, exps[i]); end
    end
    @(negedge clk); drive(1, 0, 3'd2, 32'h6C, 0, 0); #1;
    vectors++; if (load_data !== ref_mem[27] || fault !== 1'b0) begin
      miscompares++; $display("FAIL load_last_word: got %h fault %b expected %h fault 0", load_data, fault, ref_mem[27]); end
    idle_cycle();
  endtask

  task automatic test_sb_rmw();
    @(negedge clk); drive(1, 1, 3'd0, 32'h0E, 32'h12345677, 0); #1;
    vectors++; if (stall !== 1'b1 || mem_read_en !== 1'b1 || mem_write_en !== 1'b0) begin
      miscompares++; $display("FAIL sb_cycle1: got stall %b rd %b wr %b expected 1 1 0", stall, mem_read_en, mem_write_en); end
    @(negedge clk); #1;
    vectors++; if (mem_write_en !== 1'b1 || mem_read_en !== 1'b0 || stall !== 1'b0) begin
      miscompares++; $display("FAIL sb_cycle2_ctl: got wr %b rd %b stall %b expected 1 0 0", mem_write_en, mem_read_en, stall); end
    vectors++; if (mem_wdata !== 32'h8877AABB || mem_addr !== 32'h0C) begin
      miscompares++; $display("FAIL sb_cycle2_data: got %h @%h expected 8877aabb @0000000c", mem_wdata, mem_addr); end
    @(posedge clk); ref_mem[3] = 32'h8877AABB;
    @(negedge clk); drive(1, 0, 3'd2, 32'h0C, 0, 0); #1;
    vectors++; if (load_data !== 32'h8877AABB) begin miscompares++; $display("FAIL sb_readback: got %h expected 8877aabb", load_data); end
    idle_cycle();
  endtask

  task automatic test_sw();
    @(negedge clk); drive(1, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0); #1;
    vectors++; if (mem_write_en !== 1'b1 || stall !== 1'b0 || mem_wdata !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL sw: got wr %b stall %b data %h expected 1 0 deadbeef", mem_write_en, stall, mem_wdata); end
    @(posedge clk); ref_mem[4] = 32'hDEADBEEF;
    @(negedge clk); drive(1, 0, 3'd2, 32'h10, 0, 0); #1;
    vectors++; if (load_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_readback: got %h expected deadbeef", load_data); end
    idle_cycle();
  endtask

  task automatic test_faults();
    @(negedge clk); drive(1, 0, 3'd2, 32'h06, 0, 0); #1;
    vectors++; if (fault !== 1'b1 || fault_cause !== 2'd1) begin miscompares++; $display("FAIL misaligned_lw: got %b/%0d expected 1/1", fault, fault_cause); end
    vectors++; if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || stall !== 1'b0 || load_data !== 32'd0) begin
      miscompares++; $display("FAIL fault_suppress: got rd %b wr %b stall %b data %h expected 0 0 0 0", mem_read_en, mem_write_en, stall, load_data); end
    @(posedge clk); #1;
    vectors++; if (fault_sticky !== 1'b1 || fault_addr_q !== 32'h06) begin
      miscompares++; $display("FAIL sticky_first: got %b %h expected 1 00000006", fault_sticky, fault_addr_q); end
    @(negedge clk); drive(1, 1, 3'd1, 32'h71, 32'h5555, 0); #1;
    vectors++; if (fault_cause !== 2'd1 || stall !== 1'b0) begin miscompares++; $display("FAIL sh_mis_oor: got %0d stall %b expected 1 stall 0", fault_cause, stall); end
    @(posedge clk); #1;
    vectors++; if (fault_addr_q !== 32'h06) begin miscompares++; $display("FAIL sticky_hold: got %h expected 00000006", fault_addr_q); end
    @(negedge clk); drive(0, 0, 0, 0, 0, 1);
    @(posedge clk); #1;
    vectors++; if (fault_sticky !== 1'b0) begin miscompares++; $display("FAIL fault_clear: got %b expected 0", fault_sticky); end
    @(negedge clk); drive(1, 1, 3'd2, 32'h70, 32'h1, 0); #1;
    vectors++; if (fault_cause !== 2'd2 || mem_write_en !== 1'b0) begin
      miscompares++; $display("FAIL oor_sw: got %0d wr %b expected 2 wr 0", fault_cause, mem_write_en); end
    @(negedge clk); drive(1, 0, 3'd3, 32'h20, 0, 1); #1;
    vectors++; if (fault_cause !== 2'd3) begin miscompares++; $display("FAIL illegal_f3: got %0d expected 3", fault_cause); end
    @(posedge clk); #1;
    vectors++; if (fault_sticky !== 1'b1 || fault_addr_q !== 32'h20) begin
      miscompares++; $display("FAIL clear_vs_fault: got %b %h expected 1 00000020", fault_sticky, fault_addr_q); end
    @(negedge clk); drive(0, 0, 0, 0, 0, 1);
    @(posedge clk);
    idle_cycle();
  endtask

  task automatic test_reset_rmw();
    @(negedge clk); drive(1, 1, 3'd1, 32'h08, $urandom(), 0);
    @(negedge clk); reset = 1'b1; #1;
    vectors++; if (state_dbg !== 1'b1 || mem_write_en !== 1'b0 || stall !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_rmw: got state %b wr %b stall %b expected 1 0 0", state_dbg, mem_write_en, stall); end
    @(negedge clk); reset = 1'b0; drive(0, 0, 0, 0, 0, 0); #1;
    vectors++; if (state_dbg !== 1'b0 || stall !== 1'b0 || tb_mem[2] !== ref_mem[2]) begin
      miscompares++; $display("FAIL after_reset_rmw: got state %b stall %b word2 %h expected 0 0 %h", state_dbg, stall, tb_mem[2], ref_mem[2]); end
  endtask

  task automatic test_random();
    logic v, we, clr, exp_sticky;
    logic [2:0]  f3;
    logic [31:0] a, wd, exp_faddr, exp_w;
    logic [1:0]  cause;
    exp_sticky = 1'b0; exp_faddr = 32'd0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      v = ($urandom_range(0, 7) != 0); we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      a = 32'($urandom_range(0, 127)); wd = $urandom(); clr = ($urandom_range(0, 7) == 0);
      drive(v, we, f3, a, wd, clr); #1;
      cause = v ? model_cause(we, f3, a) : 2'd0;
      vectors++; if (fault_cause !== cause || fault !== (cause != 0)) begin
        miscompares++; $display("FAIL rnd_cause[%0d]: got %0d/%b expected %0d", i, fault_cause, fault, cause); end
      if (v && cause == 0 && !we) begin
        vectors++; if (load_data !== model_load(f3, a) || !mem_read_en || mem_write_en || stall || mem_addr !== (a & ~32'd3)) begin
          miscompares++; $display("FAIL rnd_load[%0d]: got %h rd %b wr %b @%h expected %h", i, load_data, mem_read_en, mem_write_en, mem_addr, model_load(f3, a)); end
      end else if (v && cause == 0 && f3 == 3'd2) begin
        vectors++; if (!mem_write_en || mem_read_en || stall || mem_wdata !== wd || mem_addr !== a) begin
          miscompares++; $display("FAIL rnd_sw[%0d]: got wr %b data %h @%h expected 1 %h @%h", i, mem_write_en, mem_wdata, mem_addr, wd, a); end
        ref_mem[a / 4] = wd;
      end else if (v && cause == 0) begin
        vectors++; if (!stall || !mem_read_en || mem_write_en) begin
          miscompares++; $display("FAIL rnd_rmw1[%0d]: got stall %b rd %b wr %b expected 1 1 0", i, stall, mem_read_en, mem_write_en); end
        exp_q.push_back(model_merge(f3, a, wd));
      end else begin
        vectors++; if (mem_read_en || mem_write_en || stall || load_data !== 32'd0) begin
          miscompares++; $display("FAIL rnd_quiet[%0d]: got rd %b wr %b stall %b data %h expected 0 0 0 0", i, mem_read_en, mem_write_en, stall, load_data); end
      end
      if (cause != 0 && (!exp_sticky || clr)) begin exp_sticky = 1'b1; exp_faddr = a; end
      else if (clr) exp_sticky = 1'b0;
      @(posedge clk); #1;
      vectors++; if (fault_sticky !== exp_sticky || fault_addr_q !== exp_faddr) begin
        miscompares++; $display("FAIL rnd_sticky[%0d]: got %b %h expected %b %h", i, fault_sticky, fault_addr_q, exp_sticky, exp_faddr); end
      if (exp_q.size() != 0) begin
        @(negedge clk); fault_clear = 1'b0; #1;
        exp_w = exp_q.pop_front();
        vectors++; if (!mem_write_en || mem_read_en || stall || fault || mem_wdata !== exp_w || mem_addr !== (a & ~32'd3)) begin
          miscompares++; $display("FAIL rnd_rmw2[%0d]: got wr %b stall %b data %h @%h expected 1 0 %h @%h", i, mem_write_en, stall, mem_wdata, mem_addr, exp_w, a & ~32'd3); end
        ref_mem[a / 4] = exp_w;
        @(posedge clk);
      end
    end
    idle_cycle();
    for (int w = 0; w < DEPTH; w++) begin
      vectors++; if (tb_mem[w] !== ref_mem[w]) begin
        miscompares++; $display("FAIL final_mem[%0d]: got %h expected %h", w, tb_mem[w], ref_mem[w]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    test_reset();
    init_mem();
    test_loads();
    test_sb_rmw();
    test_sw();
    test_faults();
    test_reset_rmw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute stage and the word-addressed data memory.
- Converts core load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Loads are extracted and extended; SB/SH use a two-cycle read-modify-write, because the memory only writes whole words.
- Detects misaligned, out-of-range and illegal-funct3 accesses and suppresses them. Keeps a sticky record of the first fault.

Parameters:
- DEPTH_WORDS, 28, number of valid memory words; word index addr[31:2] >= DEPTH_WORDS is out of range.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present; core holds all req_* stable while stall=1
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 width/sign code
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- fault_clear  in  1  clears sticky fault record
- stall  out  1  core must hold request and not advance PC
- load_data  out  32  extended load result, combinational
- fault  out  1  current request faulted, combinational
- fault_cause  out  2  0 none, 1 misaligned, 2 out-of-range, 3 illegal funct3
- fault_sticky  out  1  registered; set on first fault
- fault_addr_q  out  32  registered; req_addr of first fault
- mem_addr  out  32  word-aligned byte address {addr[31:2],2'b00}
- mem_wdata  out  32  write word
- mem_read_en  out  1  memory read enable
- mem_write_en  out  1  memory write enable (memory writes on posedge)
- mem_rdata  in  32  combinational memory read data

Behaviour:
- States: IDLE, RMW_WR. Registers: state, addr_q, merge_q, fault_sticky, fault_addr_q.
- Reset (reset=1 at posedge): state=IDLE, merge_q=0, addr_q=0, fault_sticky=0, fault_addr_q=0.
- While reset=1, combinationally force mem_read_en=0, mem_write_en=0, stall=0, fault=0, load_data=0.
- Reset during RMW_WR returns to IDLE with no write issued.
- Fault check (IDLE, req_valid=1), priority illegal > misaligned > out-of-range:
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
  - Misaligned: halfword access with addr[0]=1, or word access with addr[1:0]!=0.
  - A faulting request: fault=1, no memory enables, stall=0, load_data=0.
  - If fault_sticky=0 at the posedge: fault_sticky<=1, fault_addr_q<=req_addr.
  - fault_clear=1 clears fault_sticky. A fault in the same cycle takes priority and re-sets it with the new address.
- Loads (IDLE, valid, no fault): mem_read_en=1, mem_addr=word address, stall=0. Zero-cycle latency.
  - Byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- SW (IDLE, valid, no fault): mem_write_en=1, mem_wdata=req_wdata, stall=0. Written at that posedge.
- SB/SH (IDLE, valid, no fault): cycle 1 and cycle 2 below; total latency 2 cycles.
  - Cycle 1: mem_read_en=1, stall=1. merge_q<=mem_rdata with the selected lane(s) replaced by req_wdata[7:0] or req_wdata[15:0]. addr_q<=word address. state<=RMW_WR.
  - Cycle 2 (RMW_WR): mem_write_en=1, mem_addr=addr_q, mem_wdata=merge_q, stall=0, state<=IDLE. req_* are ignored in this state; this is the same instruction still held by the core.
- req_valid=0 in IDLE: all enables 0, stall=0, fault=0, load_data=0, mem_wdata=0.
- Never assert mem_read_en and mem_write_en together. mem_addr[1:0] is always 0.

Test Plan:
- Preload word 3 (mem index 3)=32'h8899AABB:
  - LB addr 0x0D -> load_data=32'hFFFFFFAA, stall=0.
  - LBU 0x0D -> 32'h000000AA.
  - LH 0x0E -> 32'hFFFF8899.
  - LHU 0x0C -> 32'h0000AABB.
  - LW 0x0C -> 32'h8899AABB.
- SB addr 0x0E wdata 32'h12345677 on word 32'h8899AABB:
  - Cycle 1: stall=1, mem_read_en=1.
  - Cycle 2: mem_write_en=1, mem_wdata=32'h8877AABB, mem_addr=0x0C.
  - Following LW 0x0C returns 32'h8877AABB.
- SW addr 0x10 wdata 32'hDEADBEEF -> single cycle: mem_write_en=1, stall=0. LW 0x10 then returns 32'hDEADBEEF.
- LW addr 0x06 -> fault=1, fault_cause=1, no enables, fault_sticky=1, fault_addr_q=0x06. Then SH 0x71 (misaligned and out of range) -> fault_cause=1; fault_addr_q stays 0x06. Assert fault_clear -> fault_sticky=0.
- SW addr 0x70 (index 28) -> fault_cause=2, mem_write_en=0. Load funct3=011 -> fault_cause=3.
- Start SH 0x08 and assert reset in the RMW_WR cycle -> mem_write_en=0, state IDLE, word 2 unchanged. Next cycle stall=0.
